// File: rtl/usb_aes_pkg.sv
// Shared types and constants for the USB payload to AES block path.
// Holds the block size, the padding-mode codes, the packer states and the pad byte helper.
package usb_aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;
    localparam int PAD_ZERO        = 0;
    localparam int PAD_PKCS7       = 1;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FULL  = 2'd1,
        EXTRA = 2'd2
    } packer_state_e;

    // PKCS#7 pads with the pad count itself; zero mode pads with 0x00.
    function automatic logic [7:0] pad_byte(input logic mode, input logic [7:0] count);
        return mode ? count : 8'h00;
    endfunction

endpackage

// File: rtl/aes_block_packer.sv
// Packs a byte stream into BLOCK_BYTES-wide blocks for the AES core.
// Short final blocks are padded with zeros or PKCS#7, and a full final block can be followed by a PKCS#7 all-pad block.
module aes_block_packer
    import usb_aes_pkg::*;
#(
    parameter int BLOCK_BYTES = AES_BLOCK_BYTES,
    parameter int PAD_MODE    = PAD_PKCS7
) (
    input  logic                               clk,
    input  logic                               n_rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [7:0]                         in_data,
    input  logic                               in_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [BLOCK_BYTES*8-1:0]           out_data,
    output logic                               out_last,
    output logic [$clog2(BLOCK_BYTES+1)-1:0]   out_pad_count
);

    localparam int IDX_W = $clog2(BLOCK_BYTES);
    localparam int PC_W  = $clog2(BLOCK_BYTES+1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES-1);

    packer_state_e              state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [BLOCK_BYTES*8-1:0]   data_q, data_d;
    logic                       last_q, last_d;
    logic [PC_W-1:0]            pad_q, pad_d;
    logic                       extra_q, extra_d;
    logic [7:0]                 pad_val;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            pad_q   <= '0;
            extra_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            last_q  <= last_d;
            pad_q   <= pad_d;
            extra_q <= extra_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        last_d  = last_q;
        pad_d   = pad_q;
        extra_d = extra_q;
        pad_val = pad_byte(PAD_MODE != 0, 8'(BLOCK_BYTES - 1 - int'(idx_q)));

        case (state_q)
            FILL: begin
                if (in_valid) begin
                    // Slot 0 sits at the MSB; a last byte also pads every later slot in the same cycle.
                    for (int i = 0; i < BLOCK_BYTES; i++) begin
                        if (i == int'(idx_q)) begin
                            data_d[(BLOCK_BYTES-1-i)*8 +: 8] = in_data;
                        end else if (in_last && (i > int'(idx_q))) begin
                            data_d[(BLOCK_BYTES-1-i)*8 +: 8] = pad_val;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = FULL;
                        pad_d   = '0;
                        last_d  = in_last && (PAD_MODE == 0);
                        extra_d = in_last && (PAD_MODE != 0);
                    end else if (in_last) begin
                        state_d = FULL;
                        pad_d   = PC_W'(BLOCK_BYTES - 1 - int'(idx_q));
                        last_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            FULL: begin
                if (out_ready) begin
                    if (extra_q) begin
                        state_d = EXTRA;
                        data_d  = {BLOCK_BYTES{8'(BLOCK_BYTES)}};
                        pad_d   = PC_W'(BLOCK_BYTES);
                        last_d  = 1'b1;
                        extra_d = 1'b0;
                    end else begin
                        state_d = FILL;
                        idx_d   = '0;
                        data_d  = '0;
                        last_d  = 1'b0;
                        pad_d   = '0;
                    end
                end
            end
            EXTRA: begin
                if (out_ready) begin
                    state_d = FILL;
                    idx_d   = '0;
                    data_d  = '0;
                    last_d  = 1'b0;
                    pad_d   = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    assign in_ready      = (state_q == FILL);
    assign out_valid     = (state_q != FILL);
    assign out_data      = data_q;
    assign out_last      = last_q;
    assign out_pad_count = pad_q;

endmodule
